// File: rtl/passcode_checker.sv
// Passcode entry front end for the alarm FSM: synchronizes and debounces the keypad
// buttons, collects CODE_LEN digits, compares them with PASSCODE and locks out after
// MAX_FAILS consecutive wrong entries.
module passcode_checker #(
  parameter int                          CODE_LEN        = 4,
  parameter int                          DIGIT_W         = 4,
  parameter logic [CODE_LEN*DIGIT_W-1:0] PASSCODE        = 16'h3216,
  parameter int                          MAX_FAILS       = 3,
  parameter int                          DEBOUNCE_CYCLES = 500000,
  parameter int                          CORRECT_HOLD    = 50000000,
  parameter int                          LOCKOUT_CYCLES  = 500000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DIGIT_W-1:0] digit_sw,
  input  logic               btn_enter_n,
  input  logic               btn_clear_n,
  output logic               passcode_correct,
  output logic               passcode_wrong,
  output logic [3:0]         digits_entered,
  output logic [3:0]         fail_count,
  output logic               locked_out
);

  localparam int BUF_W  = CODE_LEN * DIGIT_W;
  localparam int DB_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_W = (CORRECT_HOLD    > 2) ? $clog2(CORRECT_HOLD)    : 1;
  localparam int LOCK_W = (LOCKOUT_CYCLES  > 2) ? $clog2(LOCKOUT_CYCLES)  : 1;

  localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(CORRECT_HOLD - 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST   = LOCK_W'(LOCKOUT_CYCLES - 1);
  localparam logic [3:0]        DIGITS_LAST = 4'(CODE_LEN - 1);
  localparam logic [3:0]        FAIL_LAST   = 4'(MAX_FAILS - 1);
  localparam logic [3:0]        FAIL_MAX    = 4'(MAX_FAILS);

  localparam int BTN_ENTER = 0;
  localparam int BTN_CLEAR = 1;

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_CHECK   = 2'd1,
    ST_CORRECT = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic [DIGIT_W-1:0] digit_sync1_q, digit_sync2_q;
  logic [1:0]         btn_sync1_q, btn_sync2_q;
  logic [1:0]         btn_deb_q, btn_deb_d;
  logic [1:0]         btn_fall_q, btn_fall_d;
  logic [DB_W-1:0]    db_cnt_q [2];
  logic [DB_W-1:0]    db_cnt_d [2];
  logic               enter_p, clear_p;

  // NOTE: every flop, including the counter array, is reset so a mid-run reset
  // cannot leave a half-debounced press behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_sync1_q <= '0;
      digit_sync2_q <= '0;
      btn_sync1_q   <= 2'b11;
      btn_sync2_q   <= 2'b11;
      btn_deb_q     <= 2'b11;
      btn_fall_q    <= 2'b00;
      for (int b = 0; b < 2; b++) db_cnt_q[b] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep each synchronizer stage one cycle apart.
      digit_sync1_q <= digit_sw;
      digit_sync2_q <= digit_sync1_q;
      btn_sync1_q   <= {btn_clear_n, btn_enter_n};
      btn_sync2_q   <= btn_sync1_q;
      btn_deb_q     <= btn_deb_d;
      btn_fall_q    <= btn_fall_d;
      for (int b = 0; b < 2; b++) db_cnt_q[b] <= db_cnt_d[b];
    end
  end

  // A level change is accepted only after DEBOUNCE_CYCLES stable cycles; any
  // return to the current debounced level restarts the count.
  always_comb begin
    // NOTE: defaults first so no path through this block infers a latch.
    btn_deb_d = btn_deb_q;
    for (int b = 0; b < 2; b++) begin
      db_cnt_d[b] = '0;
      if (btn_sync2_q[b] != btn_deb_q[b]) begin
        if (db_cnt_q[b] == DB_LAST) begin
          btn_deb_d[b] = btn_sync2_q[b];
        end else begin
          db_cnt_d[b] = db_cnt_q[b] + 1'b1;
        end
      end
    end
    btn_fall_d = btn_deb_q & ~btn_deb_d;
  end

  assign enter_p = btn_fall_q[BTN_ENTER];
  assign clear_p = btn_fall_q[BTN_CLEAR];

  // ---------------------------------------------------------------------------
  // Entry / check FSM
  // ---------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [BUF_W-1:0]    buf_q, buf_d;
  logic [3:0]          digits_q, digits_d;
  logic [3:0]          fail_q, fail_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic                wrong_q, wrong_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ENTRY;
      buf_q      <= '0;
      digits_q   <= '0;
      fail_q     <= '0;
      hold_cnt_q <= '0;
      lock_cnt_q <= '0;
      wrong_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      digits_q   <= digits_d;
      fail_q     <= fail_d;
      hold_cnt_q <= hold_cnt_d;
      lock_cnt_q <= lock_cnt_d;
      wrong_q    <= wrong_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    digits_d   = digits_q;
    fail_d     = fail_q;
    hold_cnt_d = hold_cnt_q;
    lock_cnt_d = lock_cnt_q;
    wrong_d    = 1'b0;

    unique case (state_q)
      ST_ENTRY: begin
        // Clear takes priority over a coincident enter.
        if (clear_p) begin
          buf_d    = '0;
          digits_d = '0;
        end else if (enter_p) begin
          buf_d    = {buf_q[BUF_W-DIGIT_W-1:0], digit_sync2_q};
          digits_d = digits_q + 4'd1;
          if (digits_q == DIGITS_LAST) state_d = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (buf_q == PASSCODE) begin
          fail_d     = '0;
          hold_cnt_d = '0;
          state_d    = ST_CORRECT;
        end else begin
          wrong_d = 1'b1;
          if (fail_q < FAIL_LAST) begin
            fail_d   = fail_q + 4'd1;
            buf_d    = '0;
            digits_d = '0;
            state_d  = ST_ENTRY;
          end else begin
            // The full buffer is kept until the lockout expires.
            fail_d     = FAIL_MAX;
            lock_cnt_d = '0;
            state_d    = ST_LOCKOUT;
          end
        end
      end

      ST_CORRECT: begin
        if (hold_cnt_q == HOLD_LAST) begin
          buf_d    = '0;
          digits_d = '0;
          state_d  = ST_ENTRY;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end

      ST_LOCKOUT: begin
        if (lock_cnt_q == LOCK_LAST) begin
          fail_d   = '0;
          buf_d    = '0;
          digits_d = '0;
          state_d  = ST_ENTRY;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end

      default: state_d = ST_ENTRY;
    endcase
  end

  always_comb begin
    passcode_correct = (state_q == ST_CORRECT);
    locked_out       = (state_q == ST_LOCKOUT);
    passcode_wrong   = wrong_q;
    digits_entered   = digits_q;
    fail_count       = fail_q;
  end

endmodule

// File: tb/tb_passcode_checker.sv
// Directed bench for passcode_checker with shortened debounce, hold and lockout times.
module tb_passcode_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] digit_sw;
  logic       btn_enter_n;
  logic       btn_clear_n;
  logic       passcode_correct;
  logic       passcode_wrong;
  logic [3:0] digits_entered;
  logic [3:0] fail_count;
  logic       locked_out;

  int n_checks = 0;
  int n_errors = 0;

  passcode_checker #(
    .CODE_LEN       (4),
    .DIGIT_W        (4),
    .PASSCODE       (16'h3216),
    .MAX_FAILS      (3),
    .DEBOUNCE_CYCLES(4),
    .CORRECT_HOLD   (8),
    .LOCKOUT_CYCLES (20)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .digit_sw        (digit_sw),
    .btn_enter_n     (btn_enter_n),
    .btn_clear_n     (btn_clear_n),
    .passcode_correct(passcode_correct),
    .passcode_wrong  (passcode_wrong),
    .digits_entered  (digits_entered),
    .fail_count      (fail_count),
    .locked_out      (locked_out)
  );

  always #5 clk = ~clk;

  // Run-length monitors for the level outputs, plus total passcode_wrong high cycles.
  int corr_len = 0, last_corr_len = 0, corr_runs = 0;
  int lock_len = 0, last_lock_len = 0, lock_runs = 0;
  int wrong_cycles = 0;

  always @(negedge clk) begin
    if (passcode_correct) corr_len <= corr_len + 1;
    else if (corr_len != 0) begin
      last_corr_len <= corr_len;
      corr_runs     <= corr_runs + 1;
      corr_len      <= 0;
    end
    if (locked_out) lock_len <= lock_len + 1;
    else if (lock_len != 0) begin
      last_lock_len <= lock_len;
      lock_runs     <= lock_runs + 1;
      lock_len      <= 0;
    end
    if (passcode_wrong) wrong_cycles <= wrong_cycles + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic press(input logic do_enter, input logic do_clear, input logic [3:0] d);
    digit_sw = d;
    @(negedge clk);
    btn_enter_n = !do_enter;
    btn_clear_n = !do_clear;
    repeat (10) @(negedge clk);
    btn_enter_n = 1'b1;
    btn_clear_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic enter_code(input logic [15:0] code);
    for (int i = 3; i >= 0; i--) press(1'b1, 1'b0, code[i*4 +: 4]);
  endtask

  // Holds enter low on digit d until sig goes high; returns negedges waited.
  task automatic hold_until(input logic [3:0] d, input int which, output int waited);
    logic hit;
    digit_sw = d;
    @(negedge clk);
    btn_enter_n = 1'b0;
    waited = 0;
    hit    = 1'b0;
    while (!hit && waited < 30) begin
      @(negedge clk);
      waited++;
      case (which)
        0:       hit = (digits_entered == 4'd4);
        1:       hit = passcode_correct;
        default: hit = locked_out;
      endcase
    end
  endtask

  task automatic release_enter();
    btn_enter_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_correct"}, passcode_correct, 0);
    check({tag, "_wrong"},   passcode_wrong,   0);
    check({tag, "_digits"},  digits_entered,   0);
    check({tag, "_fails"},   fail_count,       0);
    check({tag, "_locked"},  locked_out,       0);
  endtask

  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 check_reset_values(tag);
    btn_enter_n = 1'b1;
    btn_clear_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, runs0, wrong0;

    rst_n = 1'b0; digit_sw = '0; btn_enter_n = 1'b1; btn_clear_n = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Scenario 1: correct entry with exact output timing.
    press(1'b1, 1'b0, 4'd3); check("s1_d1", digits_entered, 1);
    press(1'b1, 1'b0, 4'd2); check("s1_d2", digits_entered, 2);
    press(1'b1, 1'b0, 4'd1); check("s1_d3", digits_entered, 3);
    hold_until(4'd6, 0, n);
    check("s1_latency", n, 7);
    check("s1_check_cycle_correct", passcode_correct, 0);
    @(negedge clk);
    n = 0;
    while (passcode_correct && n < 30) begin
      n++;
      @(negedge clk);
    end
    check("s1_correct_len", n, 8);
    check("s1_digits_after", digits_entered, 0);
    check("s1_fails", fail_count, 0);
    release_enter();

    // Scenario 2: bounce rejection.
    digit_sw = 4'd5;
    @(negedge clk);
    for (int r = 0; r < 3; r++) begin
      btn_enter_n = 1'b0; repeat (3) @(negedge clk);
      btn_enter_n = 1'b1; @(negedge clk);
    end
    repeat (6) @(negedge clk);
    check("s2_bounce_ignored", digits_entered, 0);
    btn_enter_n = 1'b0; repeat (10) @(negedge clk);
    release_enter();
    check("s2_one_digit", digits_entered, 1);
    press(1'b0, 1'b1, 4'd0);
    check("s2_cleared", digits_entered, 0);

    // Scenario 3: three wrong entries, lockout, then recovery.
    wrong0 = wrong_cycles;
    enter_code(16'h1234);
    check("s3_fail1", fail_count, 1);
    check("s3_digits1", digits_entered, 0);
    check("s3_wrong1", wrong_cycles - wrong0, 1);
    enter_code(16'h1234);
    check("s3_fail2", fail_count, 2);
    check("s3_wrong2", wrong_cycles - wrong0, 2);
    press(1'b1, 1'b0, 4'd1);
    press(1'b1, 1'b0, 4'd2);
    press(1'b1, 1'b0, 4'd3);
    runs0 = lock_runs;
    hold_until(4'd4, 2, n);
    check("s3_lock_latency", n, 8);
    check("s3_wrong_pulse", passcode_wrong, 1);
    check("s3_fail3", fail_count, 3);
    btn_enter_n = 1'b1; digit_sw = 4'd3;
    repeat (7) @(negedge clk);
    btn_enter_n = 1'b0;
    repeat (7) @(negedge clk);
    check("s3_locked_press_ignored", digits_entered, 4);
    check("s3_still_locked", locked_out, 1);
    check("s3_no_correct", passcode_correct, 0);
    btn_enter_n = 1'b1;
    n = 0;
    while (locked_out && n < 40) begin
      n++;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("s3_lock_len", last_lock_len, 20);
    check("s3_lock_runs", lock_runs - runs0, 1);
    check("s3_wrong_total", wrong_cycles - wrong0, 3);
    check("s3_fail_cleared", fail_count, 0);
    check("s3_digits_cleared", digits_entered, 0);
    runs0 = corr_runs;
    enter_code(16'h3216);
    check("s3_recover_runs", corr_runs - runs0, 1);
    check("s3_recover_len", last_corr_len, 8);

    // Scenario 4: clear, then coincident clear and enter.
    press(1'b1, 1'b0, 4'd3);
    press(1'b1, 1'b0, 4'd2);
    check("s4_two_digits", digits_entered, 2);
    press(1'b0, 1'b1, 4'd0);
    check("s4_cleared", digits_entered, 0);
    runs0 = corr_runs;
    enter_code(16'h3216);
    check("s4_correct_runs", corr_runs - runs0, 1);
    check("s4_correct_len", last_corr_len, 8);
    press(1'b1, 1'b1, 4'd9);
    check("s4_both_pressed", digits_entered, 0);
    press(1'b1, 1'b0, 4'd3);
    check("s4_fresh_digit", digits_entered, 1);
    press(1'b0, 1'b1, 4'd0);

    // Scenario 5: reset during CORRECT and during LOCKOUT.
    press(1'b1, 1'b0, 4'd3);
    press(1'b1, 1'b0, 4'd2);
    press(1'b1, 1'b0, 4'd1);
    hold_until(4'd6, 1, n);
    check("s5_correct_seen", passcode_correct, 1);
    repeat (2) @(negedge clk);
    async_reset("s5_rst_correct");
    enter_code(16'h1234);
    enter_code(16'h1234);
    check("s5_fail2", fail_count, 2);
    press(1'b1, 1'b0, 4'd1);
    press(1'b1, 1'b0, 4'd2);
    press(1'b1, 1'b0, 4'd3);
    hold_until(4'd4, 2, n);
    check("s5_locked_seen", locked_out, 1);
    repeat (9) @(negedge clk);
    async_reset("s5_rst_lock");
    press(1'b1, 1'b0, 4'd3);
    check("s5_first_digit", digits_entered, 1);
    runs0 = corr_runs;
    press(1'b1, 1'b0, 4'd2);
    press(1'b1, 1'b0, 4'd1);
    press(1'b1, 1'b0, 4'd6);
    check("s5_correct_after", corr_runs - runs0, 1);
    check("s5_digits_end", digits_entered, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
